// File: rtl/frame_seq_ctrl.sv
// Frame-level acquisition sequencer in front of the quad pixel-readout FSM.
// Gates the readout enable per frame, waits for FIFO room, handles abort/PLL loss.
module frame_seq_ctrl #(
   parameter int FRAME_WORDS  = 1024,
   parameter int FREE_W       = 12,
   parameter int QUIET_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic [15:0]       num_frames,
   input  logic [15:0]       gap_cycles,
   input  logic              pll_locked,
   input  logic              fifo_wr,
   input  logic              fifo_full,
   input  logic [FREE_W-1:0] fifo_free,
   output logic              fsm_en,
   output logic              busy,
   output logic [15:0]       frame_cnt,
   output logic              done,
   output logic              aborted,
   output logic              ovf_err,
   output logic              pll_err
);

   localparam int WCW = $clog2(FRAME_WORDS) + 1;
   localparam int QW  = $clog2(QUIET_CYCLES) + 1;

   localparam logic [WCW-1:0]  WC_PEN   = WCW'(FRAME_WORDS - 2);
   localparam logic [WCW-1:0]  WC_LAST  = WCW'(FRAME_WORDS - 1);
   localparam logic [QW-1:0]   Q_LAST   = QW'(QUIET_CYCLES - 1);
   localparam logic [FREE_W:0] FREE_MIN = (FREE_W + 1)'(FRAME_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_RUN,
      S_GAP,
      S_DRAIN
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [WCW-1:0] r_word_cnt;
   logic [15:0]    r_frame_cnt;
   logic [15:0]    r_gap_cnt;
   logic [QW-1:0]  r_quiet;
   logic           r_cont;
   logic [15:0]    r_nframes;
   logic [15:0]    r_gap;
   logic           r_fsm_en;
   logic           r_done;
   logic           r_aborted;
   logic           r_ovf;
   logic           r_pll_err;

   logic        w_start;
   logic        w_space;
   logic        w_last;
   logic        w_pen;
   logic        w_abort;
   logic [15:0] w_fcnt_nxt;
   logic        w_all;
   logic        w_gap_end;
   logic        w_quiet_end;

   logic w_busy;
   logic w_en_nxt;
   logic w_frame_done;
   logic w_done_set;
   logic w_abort_set;
   logic w_pll_set;

   assign w_start     = (r_state == S_IDLE) && start;
   assign w_space     = ({1'b0, fifo_free} >= FREE_MIN) && pll_locked;
   assign w_last      = fifo_wr && (r_word_cnt == WC_LAST);
   assign w_pen       = fifo_wr && (r_word_cnt == WC_PEN);
   assign w_abort     = stop || !pll_locked;
   assign w_fcnt_nxt  = (r_frame_cnt == 16'hFFFF) ? r_frame_cnt
                                                  : r_frame_cnt + 16'd1;
   assign w_all       = !r_cont && (w_fcnt_nxt == r_nframes);
   assign w_gap_end   = (r_gap_cnt == r_gap - 16'd1);
   assign w_quiet_end = !fifo_wr && (r_quiet == Q_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A completed frame takes priority over a coincident abort; the abort
   // then routes to DRAIN instead of finishing the run.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (stop)         w_next = S_IDLE;
            else if (w_space) w_next = S_RUN;
         end
         S_RUN: begin
            if (w_last) begin
               if (w_abort)              w_next = S_DRAIN;
               else if (w_all)           w_next = S_IDLE;
               else if (r_gap == 16'd0)  w_next = S_WAIT;
               else                      w_next = S_GAP;
            end else if (w_abort) begin
               w_next = S_DRAIN;
            end
         end
         S_GAP: begin
            if (stop)           w_next = S_IDLE;
            else if (w_gap_end) w_next = S_WAIT;
         end
         S_DRAIN: begin
            if (w_quiet_end) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy       = (r_state != S_IDLE);
      w_en_nxt     = 1'b0;
      w_frame_done = 1'b0;
      w_done_set   = 1'b0;
      w_abort_set  = 1'b0;
      w_pll_set    = 1'b0;
      case (r_state)
         S_WAIT: begin
            w_en_nxt    = (w_next == S_RUN);
            w_abort_set = stop;
         end
         S_RUN: begin
            // Drop en one word early so the readout FSM does not relaunch.
            w_en_nxt     = r_fsm_en && !w_abort && !w_pen;
            w_frame_done = w_last;
            w_done_set   = w_last && !w_abort && w_all;
            w_pll_set    = !pll_locked;
         end
         S_GAP: begin
            w_abort_set = stop;
         end
         S_DRAIN: begin
            w_abort_set = w_quiet_end;
         end
         default: begin
            w_en_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm_en <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_fsm_en <= w_en_nxt;
         r_done   <= w_done_set;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cont    <= 1'b0;
         r_nframes <= 16'd0;
         r_gap     <= 16'd0;
      end else if (w_start) begin
         r_cont    <= continuous;
         r_nframes <= (num_frames == 16'd0) ? 16'd1 : num_frames;
         r_gap     <= gap_cycles;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt <= 16'd0;
         r_aborted   <= 1'b0;
         r_ovf       <= 1'b0;
         r_pll_err   <= 1'b0;
      end else if (w_start) begin
         r_frame_cnt <= 16'd0;
         r_aborted   <= 1'b0;
         r_ovf       <= 1'b0;
         r_pll_err   <= 1'b0;
      end else begin
         if (w_frame_done)                   r_frame_cnt <= w_fcnt_nxt;
         if (w_abort_set)                    r_aborted   <= 1'b1;
         if (w_pll_set)                      r_pll_err   <= 1'b1;
         if (w_busy && fifo_wr && fifo_full) r_ovf       <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_cnt <= '0;
         r_gap_cnt  <= 16'd0;
         r_quiet    <= '0;
      end else begin
         if (r_state == S_WAIT)
            r_word_cnt <= '0;
         else if (r_state == S_RUN && fifo_wr)
            r_word_cnt <= r_word_cnt + 1'b1;

         if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 16'd1;
         else                  r_gap_cnt <= 16'd0;

         if (r_state == S_DRAIN && !fifo_wr) r_quiet <= r_quiet + 1'b1;
         else                                r_quiet <= '0;
      end
   end

   assign fsm_en    = r_fsm_en;
   assign busy      = w_busy;
   assign frame_cnt = r_frame_cnt;
   assign done      = r_done;
   assign aborted   = r_aborted;
   assign ovf_err   = r_ovf;
   assign pll_err   = r_pll_err;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Self-checking bench for frame_seq_ctrl; emulates the readout FSM
// and predicts run-level outcomes from word counts and event timing.
module tb_frame_seq_ctrl;

   localparam int FW = 1024;
   localparam int QC = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        continuous = 1'b0;
   logic [15:0] num_frames = 16'd0;
   logic [15:0] gap_cycles = 16'd0;
   logic        pll_locked = 1'b1;
   logic        fifo_wr = 1'b0;
   logic        fifo_full = 1'b0;
   logic [11:0] fifo_free = 12'd2048;
   logic        fsm_en;
   logic        busy;
   logic [15:0] frame_cnt;
   logic        done;
   logic        aborted;
   logic        ovf_err;
   logic        pll_err;

   frame_seq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .num_frames (num_frames),
      .gap_cycles (gap_cycles),
      .pll_locked (pll_locked),
      .fifo_wr    (fifo_wr),
      .fifo_full  (fifo_full),
      .fifo_free  (fifo_free),
      .fsm_en     (fsm_en),
      .busy       (busy),
      .frame_cnt  (frame_cnt),
      .done       (done),
      .aborted    (aborted),
      .ovf_err    (ovf_err),
      .pll_err    (pll_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] free;
      logic        pll;
      logic        exp_en;
   } wvec_t;

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;
   int last_wr = 0;
   int words = 0;
   int rises = 0;
   int dones = 0;
   int rd_left = 0;
   int dens = 100;
   int stop_at = 0;
   bit rd_auto = 1'b1;
   bit full_rand = 1'b0;
   bit ovf_exp = 1'b0;
   logic en_q = 1'b0;
   int gapd_q[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: observe the edge's results, then drive the next inputs.
   task automatic cyc();
      logic w;
      logic f;
      @(posedge clk);
      cyc_n++;
      w = fifo_wr;
      f = fifo_full;
      #1;
      if (w) begin
         last_wr = cyc_n;
         words++;
      end
      if (w && f) ovf_exp = 1'b1;
      if (done) dones++;
      if (fsm_en && !en_q) begin
         rises++;
         gapd_q.push_back(cyc_n - last_wr);
      end
      en_q = fsm_en;
      stop = 1'b0;
      if (rd_auto && rd_left == 0 && fsm_en) rd_left = FW;
      fifo_wr = (rd_left > 0) && ($urandom_range(99) < dens);
      if (fifo_wr) rd_left--;
      if (fifo_wr && words + 1 == stop_at) stop = 1'b1;
      fifo_full = full_rand && ($urandom_range(63) == 0);
   endtask

   task automatic go(input bit c, input int nf, input int g);
      continuous = c;
      num_frames = 16'(nf);
      gap_cycles = 16'(g);
      start = 1'b1;
      words = 0;
      rises = 0;
      dones = 0;
      stop_at = 0;
      ovf_exp = 1'b0;
      gapd_q.delete();
      cyc();
      start = 1'b0;
      num_frames = 16'($urandom);
      gap_cycles = 16'($urandom);
      continuous = $urandom_range(1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy && n < budget) begin
         cyc();
         n++;
      end
      chk(name, busy, 0);
   endtask

   task automatic until_words(input int w);
      int n = 0;
      while (words < w && n < 8000) begin
         cyc();
         n++;
      end
      chk("words_reached", words >= w, 1);
   endtask

   task automatic until_stop();
      int n = 0;
      while (!stop && n < 8000) begin
         cyc();
         n++;
      end
      chk("stop_reached", stop, 1);
   endtask

   initial begin
      wvec_t tv[6];
      int s_cyc;
      tv[0] = '{12'd1000, 1'b1, 1'b0};
      tv[1] = '{12'd1023, 1'b1, 1'b0};
      tv[2] = '{12'd1024, 1'b0, 1'b0};
      tv[3] = '{12'd1024, 1'b1, 1'b1};
      tv[4] = '{12'd2048, 1'b1, 1'b1};
      tv[5] = '{12'd4095, 1'b1, 1'b1};

      repeat (3) cyc();
      chk("rst_outs", {fsm_en, busy, done, aborted, ovf_err, pll_err}, 0);
      chk("rst_fcnt", frame_cnt, 0);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_busy", busy, 0);

      // Two frames with a 10-cycle gap.
      go(0, 2, 10);
      wait_idle(6000, "t1_idle");
      chk("t1_rises", rises, 2);
      chk("t1_gap", gapd_q.size() > 1 ? gapd_q[1] : -1, 11);
      chk("t1_fcnt", frame_cnt, 2);
      chk("t1_dones", dones, 1);
      chk("t1_aborted", aborted, 0);

      // Space/lock threshold table.
      rd_auto = 1'b0;
      foreach (tv[i]) begin
         fifo_free = tv[i].free;
         pll_locked = tv[i].pll;
         go(0, 1, 0);
         repeat (3) cyc();
         chk("tv_en", fsm_en, tv[i].exp_en);
         chk("tv_busy", busy, 1);
         stop = 1'b1;
         cyc();
         s_cyc = cyc_n;
         chk("tv_en_stop", fsm_en, 0);
         if (tv[i].exp_en) begin
            wait_idle(200, "tv_drain");
            chk("tv_drain_len", cyc_n - s_cyc, QC);
         end else begin
            chk("tv_wait_stop", busy, 0);
         end
         chk("tv_aborted", aborted, 1);
      end
      pll_locked = 1'b1;

      // Space arrives late.
      fifo_free = 12'd1000;
      go(0, 1, 0);
      repeat (5) cyc();
      chk("ws_hold", fsm_en, 0);
      fifo_free = 12'd1024;
      cyc();
      chk("ws_rise", fsm_en, 1);
      stop = 1'b1;
      cyc();
      wait_idle(200, "ws_idle");
      rd_auto = 1'b1;
      fifo_free = 12'd2048;

      // Continuous run aborted 300 words into frame 3.
      go(1, 0, 3);
      stop_at = 2 * FW + 300;
      until_stop();
      rd_left = 200;
      cyc();
      chk("c_en_drop", fsm_en, 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("c_start_ign", busy, 1);
      chk("c_fcnt_keep", frame_cnt, 2);
      wait_idle(1000, "c_idle");
      chk("c_drain_len", cyc_n - last_wr, QC);
      chk("c_words", words, 2 * FW + 500);
      chk("c_fcnt", frame_cnt, 2);
      chk("c_aborted", aborted, 1);
      chk("c_dones", dones, 0);

      // PLL loss mid-frame.
      go(0, 3, 5);
      until_words(500);
      pll_locked = 1'b0;
      cyc();
      rd_left = 0;
      chk("p_en_drop", fsm_en, 0);
      chk("p_err", pll_err, 1);
      wait_idle(200, "p_idle");
      chk("p_aborted", aborted, 1);
      chk("p_fcnt", frame_cnt, 0);
      pll_locked = 1'b1;
      go(0, 1, 0);
      chk("p_clr_err", pll_err, 0);
      chk("p_clr_abt", aborted, 0);
      wait_idle(3000, "p2_idle");
      chk("p2_fcnt", frame_cnt, 1);
      chk("p2_dones", dones, 1);

      // Overflow flag, and num_frames = 0 runs one frame.
      go(0, 0, 0);
      until_words(100);
      fifo_full = fifo_wr;
      cyc();
      chk("o_set", ovf_err, 1);
      wait_idle(3000, "o_idle");
      chk("o_sticky", ovf_err, 1);
      chk("o_rises", rises, 1);
      chk("o_fcnt", frame_cnt, 1);
      chk("o_dones", dones, 1);

      // Word 1023/1024 boundary with stop on the last word.
      go(0, 3, 0);
      stop_at = FW;
      until_words(FW - 2);
      chk("b_en_1022", fsm_en, 1);
      cyc();
      chk("b_en_1023", fsm_en, 0);
      chk("b_fcnt_1023", frame_cnt, 0);
      cyc();
      chk("b_fcnt_1024", frame_cnt, 1);
      chk("b_drain", busy, 1);
      wait_idle(200, "b_idle");
      chk("b_drain_len", cyc_n - last_wr, QC);
      chk("b_aborted", aborted, 1);
      chk("b_dones", dones, 0);

      // Stop during the inter-frame gap.
      go(0, 2, 20);
      until_words(FW);
      repeat (3) cyc();
      stop = 1'b1;
      cyc();
      chk("g_idle", busy, 0);
      chk("g_aborted", aborted, 1);
      chk("g_fcnt", frame_cnt, 1);

      // Asynchronous reset mid-frame.
      go(0, 1, 0);
      until_words(50);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_en", fsm_en, 0);
      chk("ar_busy", busy, 0);
      chk("ar_fcnt", frame_cnt, 0);
      rd_left = 0;
      fifo_wr = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("ar_stay", busy, 0);

      // Randomized runs against a frame/word-count model.
      for (int r = 0; r < 8; r++) begin
         int nf;
         int g;
         int nfe;
         int f;
         int k;
         bit ds;
         nf = $urandom_range(2);
         g = $urandom_range(6);
         nfe = (nf == 0) ? 1 : nf;
         dens = $urandom_range(100, 60);
         full_rand = $urandom_range(1);
         ds = ($urandom_range(2) == 0);
         f = $urandom_range(nfe, 1);
         k = ($urandom_range(3) == 0) ? FW : $urandom_range(FW, 1);
         go(0, nf, g);
         if (ds) stop_at = (f - 1) * FW + k;
         wait_idle(8000, "r_idle");
         chk("r_ovf", ovf_err, ovf_exp);
         if (ds) begin
            chk("r_fcnt", frame_cnt, stop_at / FW);
            chk("r_rises", rises, f);
            chk("r_aborted", aborted, 1);
            chk("r_dones", dones, 0);
            chk("r_drain_len", cyc_n - last_wr, QC);
         end else begin
            chk("r_fcnt", frame_cnt, nfe);
            chk("r_rises", rises, nfe);
            chk("r_aborted", aborted, 0);
            chk("r_dones", dones, 1);
            for (int i = 1; i < gapd_q.size(); i++)
               chk("r_gap", gapd_q[i], g + 1);
         end
      end
      full_rand = 1'b0;
      fifo_full = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
